// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the pipeline stage registers.
// Holds the occupancy state encoding, the NOP payload and default stage widths.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // RV32 "addi x0, x0, 0", loaded by a flush so the next stage sees a bubble
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 128;
    localparam int EX_MEM_W = 96;
    localparam int MEM_WB_W = 64;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream and downstream sides.
// The stage itself uses the slave view; whoever drives it uses the master view.
interface pipe_skid_reg_if
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = IF_ID_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used for stall monitoring; cleared only by reset.
module pipe_skid_reg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional one-entry skid buffer, flush, freeze
// and a saturating stall counter.
//
// state | meaning
// EMPTY | no beat held, out_valid low
// ONE   | main entry valid, out_valid high
// TWO   | main and skid entries valid, in_ready low (SKID=1 only)
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W    = IF_ID_W,
    parameter bit                SKID      = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    pipe_skid_reg_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e       state_q, state_nx;
    logic [DATA_W-1:0] main_q, main_nx;
    logic [DATA_W-1:0] skid_q, skid_nx;
    logic              in_ready_q;
    logic              rdy_raw;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              push;
    logic              pop;
    logic              stall_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_nx;
            main_q     <= main_nx;
            skid_q     <= skid_nx;
            in_ready_q <= (state_nx != TWO);
        end
    end

    always_comb begin
        state_nx = state_q;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = FLUSH_VAL;
            skid_nx  = FLUSH_VAL;
        end else if (!freeze) begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_nx = ONE;
                        main_nx  = bus.in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_nx = bus.in_data;
                    end else if (push && SKID) begin
                        state_nx = TWO;
                        skid_nx  = bus.in_data;
                    end else if (pop) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nx = ONE;
                        main_nx  = skid_q;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Freeze masks both handshake outputs, so push/pop cannot fire while frozen
    always_comb begin
        rdy_raw     = SKID ? in_ready_q : ((state_q == EMPTY) | bus.out_ready);
        in_ready_c  = ~freeze & rdy_raw;
        out_valid_c = ~freeze & (state_q != EMPTY);
        push        = bus.in_valid & in_ready_c;
        pop         = out_valid_c & bus.out_ready;
        stall_inc   = ((state_q != EMPTY) & ~bus.out_ready) | freeze;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = main_q;

    pipe_skid_reg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

endmodule
